decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- RV32I instruction decode stage that sits directly upstream of the register file.
- Accepts fetched instructions over a valid/ready handshake and drives rs1/rs2 read addresses to the register file in the accept cycle.
- Registers all decoded control and immediate fields so they appear one cycle later, aligned with the register file's registered read data.
- Presents results to execute over a valid/ready handshake with flush support.

Parameters:
- XLEN, 32, datapath / immediate / PC width.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- if_valid  in  1  fetch offers instruction
- if_ready  out  1  stage can accept
- if_instr  in  32  instruction word
- if_pc  in  XLEN  instruction address
- rs1_addr  out  5  combinational read address to register file
- rs2_addr  out  5  combinational read address to register file
- id_valid  out  1  decoded bundle valid
- ex_ready  in  1  execute accepts bundle
- flush  in  1  kill held bundle and block accept this cycle
- id_pc  out  XLEN  registered PC
- id_rd  out  5  destination register (0 when no writeback)
- id_imm  out  XLEN  sign-extended immediate
- id_alu_op  out  4  ALU operation
- id_alu_src_imm  out  1  operand B is immediate
- id_alu_src_pc  out  1  operand A is PC (AUIPC/JAL)
- id_reg_write  out  1  writeback enable
- id_mem_read  out  1  load
- id_mem_write  out  1  store
- id_mem_funct3  out  3  load/store size/sign
- id_branch  out  1  conditional branch (funct3 in id_mem_funct3)
- id_jump  out  1  JAL or JALR
- id_illegal  out  1  unrecognised encoding

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk. When resetn is low at a clk edge, all registered outputs become 0, id_valid=0, and the held rs addresses become 0.
- Reset mid-operation drops any bundle; no partial state survives.
- if_ready = !id_valid || ex_ready (combinational).
- accept = if_valid && if_ready && !flush.
- rs1_addr/rs2_addr = if_instr[19:15]/[24:20] when accept, otherwise held copies registered at the last accept. This keeps register file read data stable during stalls.
- A register file write to a held source register during a stall is visible in read data; execute-side forwarding covers it, not this block.
- On accept: all id_* fields are registered from if_instr/if_pc and id_valid<=1. Latency is exactly 1 cycle from accept to id_valid.
- id_valid && ex_ready && !accept: id_valid<=0.
- Simultaneous consume and accept: the new bundle replaces the old one with no bubble.
- id_valid && !ex_ready: all id_* fields are held stable.
- flush: id_valid<=0 next edge and no accept that cycle; flush has priority over accept and consume.
- Opcode decode (instr[6:0]):
  - LUI 0110111: alu PASSB, imm U
  - AUIPC 0010111: ADD, src_pc, imm U
  - JAL 1101111: jump, imm J, src_pc
  - JALR 1100111: jump, imm I
  - BRANCH 1100011: branch, imm B, rd=0
  - LOAD 0000011: mem_read, ADD, imm I
  - STORE 0100011: mem_write, ADD, imm S, rd=0
  - OP-IMM 0010011 and OP 0110011: alu from funct3/funct7[5]
  - FENCE 0001111: NOP, reg_write=0
  - Anything else: illegal=1, reg_write=0, mem_*=0
- reg_write=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.
- id_rd is forced to 0 whenever reg_write=0, and also when instr[11:7]=0.
- alu_op encoding: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB10.
  - SUB only for OP with funct7[5]=1.
  - SRA for funct3=101 with funct7[5]=1 (OP and OP-IMM).
- Immediates are sign-extended from instr[31]:
  - B immediate bit0=0, J immediate bit0=0.
  - U immediate = instr[31:12]<<12.
  - No immediate: 0.

Test Plan:
- Reset with if_valid=1 -> id_valid=0, all outputs 0, if_ready=1.
- Accept 0xFFD08293 (ADDI x5,x1,-3), ex_ready=1 -> rs1_addr=1 same cycle; next cycle id_valid=1, id_rd=5, id_imm=0xFFFFFFFD, alu_op=0, alu_src_imm=1, reg_write=1.
- Accept 0x0021A423 (SW x2,8(x3)) -> rs1_addr=3, rs2_addr=2; id_imm=8, mem_write=1, id_mem_funct3=010, id_rd=0, reg_write=0.
- Accept 0xFE000EE3 (BEQ x0,x0,-4) then hold ex_ready=0 for 3 cycles with new if_valid -> id_imm=0xFFFFFFFC, branch=1; if_ready=0, rs addresses and all id_* stable; release -> next instruction appears after exactly 1 cycle.
- Accept 0x123453B7 (LUI x7,0x12345) then 0x00000000 back-to-back, ex_ready=1 -> id_imm=0x12345000, alu_op=10, id_rd=7; next cycle id_illegal=1, reg_write=0, no bubble.
- flush asserted with id_valid=1 and if_valid=1 -> id_valid=0 next cycle, instruction not accepted (if_pc re-offered is decoded afterwards).

Source files
------------

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : RV32I instruction decode stage placed directly in front of the
//            register file. It accepts fetched instructions over a valid/ready
//            handshake and drives the rs1/rs2 read addresses in the accept
//            cycle. All decoded control and immediate fields are registered,
//            so they reach execute in the same cycle as the register file's
//            registered read data.
// Ports    : clk, resetn (synchronous, active-low)
//            if_valid / if_ready / if_instr / if_pc   - fetch side handshake
//            rs1_addr / rs2_addr                      - register file read addrs
//            id_valid / ex_ready / flush              - execute side handshake
//            id_*                                     - registered decode bundle
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic            id_valid,
    input  logic            ex_ready,
    input  logic            flush,
    output logic [XLEN-1:0] id_pc,
    output logic [4:0]      id_rd,
    output logic [XLEN-1:0] id_imm,
    output logic [3:0]      id_alu_op,
    output logic            id_alu_src_imm,
    output logic            id_alu_src_pc,
    output logic            id_reg_write,
    output logic            id_mem_read,
    output logic            id_mem_write,
    output logic [2:0]      id_mem_funct3,
    output logic            id_branch,
    output logic            id_jump,
    output logic            id_illegal
);

    // Opcodes
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_FENCE  = 7'b0001111;

    // ALU operation encoding
    localparam logic [3:0] c_ALU_ADD   = 4'd0;
    localparam logic [3:0] c_ALU_SUB   = 4'd1;
    localparam logic [3:0] c_ALU_SLL   = 4'd2;
    localparam logic [3:0] c_ALU_SLT   = 4'd3;
    localparam logic [3:0] c_ALU_SLTU  = 4'd4;
    localparam logic [3:0] c_ALU_XOR   = 4'd5;
    localparam logic [3:0] c_ALU_SRL   = 4'd6;
    localparam logic [3:0] c_ALU_SRA   = 4'd7;
    localparam logic [3:0] c_ALU_OR    = 4'd8;
    localparam logic [3:0] c_ALU_AND   = 4'd9;
    localparam logic [3:0] c_ALU_PASSB = 4'd10;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic       r_valid;
    logic [4:0] r_rs1_hold;
    logic [4:0] r_rs2_hold;
    logic       w_accept;

    assign if_ready = !r_valid || ex_ready;
    assign w_accept = if_valid && if_ready && !flush;
    assign id_valid = r_valid;

    // Outside an accept the read addresses stay on the last accepted
    // instruction so the register file read data stays stable in a stall.
    assign rs1_addr = w_accept ? if_instr[19:15] : r_rs1_hold;
    assign rs2_addr = w_accept ? if_instr[24:20] : r_rs2_hold;

    // ------------------------------------------------------------------
    // Combinational decode of the offered instruction
    // ------------------------------------------------------------------
    logic [6:0]         w_opcode;
    logic [2:0]         w_funct3;
    logic               w_f7b5;
    logic signed [31:0] w_imm_i;
    logic signed [31:0] w_imm_s;
    logic signed [31:0] w_imm_b;
    logic signed [31:0] w_imm_u;
    logic signed [31:0] w_imm_j;

    assign w_opcode = if_instr[6:0];
    assign w_funct3 = if_instr[14:12];
    assign w_f7b5   = if_instr[30];

    assign w_imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign w_imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign w_imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                      if_instr[30:25], if_instr[11:8], 1'b0};
    assign w_imm_u = {if_instr[31:12], 12'b0};
    assign w_imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                      if_instr[20], if_instr[30:21], 1'b0};

    logic signed [31:0] w_imm32;
    logic [3:0]         w_alu_op;
    logic               w_src_imm;
    logic               w_src_pc;
    logic               w_reg_write;
    logic               w_mem_read;
    logic               w_mem_write;
    logic [2:0]         w_mem_funct3;
    logic               w_branch;
    logic               w_jump;
    logic               w_illegal;
    logic [4:0]         w_rd;

    always_comb begin
        w_imm32      = '0;
        w_alu_op     = c_ALU_ADD;
        w_src_imm    = 1'b0;
        w_src_pc     = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_funct3 = 3'b000;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
        w_illegal    = 1'b0;

        case (w_opcode)
            c_OP_LUI: begin
                w_imm32     = w_imm_u;
                w_alu_op    = c_ALU_PASSB;
                w_src_imm   = 1'b1;
                w_reg_write = 1'b1;
            end
            c_OP_AUIPC: begin
                w_imm32     = w_imm_u;
                w_src_imm   = 1'b1;
                w_src_pc    = 1'b1;
                w_reg_write = 1'b1;
            end
            c_OP_JAL: begin
                // ALU forms the target PC + imm; the link value comes from execute
                w_imm32     = w_imm_j;
                w_src_imm   = 1'b1;
                w_src_pc    = 1'b1;
                w_jump      = 1'b1;
                w_reg_write = 1'b1;
            end
            c_OP_JALR: begin
                w_imm32     = w_imm_i;
                w_src_imm   = 1'b1;
                w_jump      = 1'b1;
                w_reg_write = 1'b1;
            end
            c_OP_BRANCH: begin
                w_imm32      = w_imm_b;
                w_branch     = 1'b1;
                w_mem_funct3 = w_funct3;
            end
            c_OP_LOAD: begin
                w_imm32      = w_imm_i;
                w_src_imm    = 1'b1;
                w_mem_read   = 1'b1;
                w_mem_funct3 = w_funct3;
                w_reg_write  = 1'b1;
            end
            c_OP_STORE: begin
                w_imm32      = w_imm_s;
                w_src_imm    = 1'b1;
                w_mem_write  = 1'b1;
                w_mem_funct3 = w_funct3;
            end
            c_OP_IMM, c_OP_REG: begin
                w_reg_write = 1'b1;
                if (w_opcode == c_OP_IMM) begin
                    w_imm32   = w_imm_i;
                    w_src_imm = 1'b1;
                end
                case (w_funct3)
                    // funct7[5] on OP-IMM ADDI is part of the immediate, not SUB
                    3'b000:  w_alu_op = (w_opcode == c_OP_REG && w_f7b5) ? c_ALU_SUB : c_ALU_ADD;
                    3'b001:  w_alu_op = c_ALU_SLL;
                    3'b010:  w_alu_op = c_ALU_SLT;
                    3'b011:  w_alu_op = c_ALU_SLTU;
                    3'b100:  w_alu_op = c_ALU_XOR;
                    3'b101:  w_alu_op = w_f7b5 ? c_ALU_SRA : c_ALU_SRL;
                    3'b110:  w_alu_op = c_ALU_OR;
                    default: w_alu_op = c_ALU_AND;
                endcase
            end
            c_OP_FENCE: begin
                // Treated as a NOP: no writeback, no memory access
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Destination is zero whenever nothing is written back
    assign w_rd = w_reg_write ? if_instr[11:7] : 5'd0;

    // ------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid        <= 1'b0;
            r_rs1_hold     <= 5'd0;
            r_rs2_hold     <= 5'd0;
            id_pc          <= '0;
            id_rd          <= 5'd0;
            id_imm         <= '0;
            id_alu_op      <= 4'd0;
            id_alu_src_imm <= 1'b0;
            id_alu_src_pc  <= 1'b0;
            id_reg_write   <= 1'b0;
            id_mem_read    <= 1'b0;
            id_mem_write   <= 1'b0;
            id_mem_funct3  <= 3'd0;
            id_branch      <= 1'b0;
            id_jump        <= 1'b0;
            id_illegal     <= 1'b0;
        end else begin
            // flush wins; accept already excludes flush
            if (flush)
                r_valid <= 1'b0;
            else if (w_accept)
                r_valid <= 1'b1;
            else if (ex_ready)
                r_valid <= 1'b0;

            if (w_accept) begin
                r_rs1_hold     <= if_instr[19:15];
                r_rs2_hold     <= if_instr[24:20];
                id_pc          <= if_pc;
                id_rd          <= w_rd;
                id_imm         <= XLEN'(w_imm32);
                id_alu_op      <= w_alu_op;
                id_alu_src_imm <= w_src_imm;
                id_alu_src_pc  <= w_src_pc;
                id_reg_write   <= w_reg_write;
                id_mem_read    <= w_mem_read;
                id_mem_write   <= w_mem_write;
                id_mem_funct3  <= w_mem_funct3;
                id_branch      <= w_branch;
                id_jump        <= w_jump;
                id_illegal     <= w_illegal;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Directed self-checking bench for decode_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk;
    logic        resetn;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        id_valid;
    logic        ex_ready;
    logic        flush;
    logic [31:0] id_pc;
    logic [4:0]  id_rd;
    logic [31:0] id_imm;
    logic [3:0]  id_alu_op;
    logic        id_alu_src_imm;
    logic        id_alu_src_pc;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic [2:0]  id_mem_funct3;
    logic        id_branch;
    logic        id_jump;
    logic        id_illegal;

    int n_checks;
    int n_errors;

    decode_stage #(.XLEN(32)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .id_valid       (id_valid),
        .ex_ready       (ex_ready),
        .flush          (flush),
        .id_pc          (id_pc),
        .id_rd          (id_rd),
        .id_imm         (id_imm),
        .id_alu_op      (id_alu_op),
        .id_alu_src_imm (id_alu_src_imm),
        .id_alu_src_pc  (id_alu_src_pc),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .id_mem_write   (id_mem_write),
        .id_mem_funct3  (id_mem_funct3),
        .id_branch      (id_branch),
        .id_jump        (id_jump),
        .id_illegal     (id_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetn   = 1'b0;
        if_valid = 1'b1;
        if_instr = 32'hFFD08293;
        if_pc    = 32'h100;
        ex_ready = 1'b1;
        flush    = 1'b0;

        // Reset with if_valid high
        repeat (3) step();
        check("rst_valid",  32'(id_valid), 32'd0);
        check("rst_imm",    id_imm, 32'd0);
        check("rst_rd",     32'(id_rd), 32'd0);
        check("rst_pc",     id_pc, 32'd0);
        check("rst_regwr",  32'(id_reg_write), 32'd0);
        check("rst_alu",    32'(id_alu_op), 32'd0);
        check("rst_ready",  32'(if_ready), 32'd1);

        // ADDI x5,x1,-3
        resetn = 1'b1;
        #1;
        check("addi_rs1_comb", 32'(rs1_addr), 32'd1);
        step();
        check("addi_valid", 32'(id_valid), 32'd1);
        check("addi_rd",    32'(id_rd), 32'd5);
        check("addi_imm",   id_imm, 32'hFFFFFFFD);
        check("addi_alu",   32'(id_alu_op), 32'd0);
        check("addi_srcimm",32'(id_alu_src_imm), 32'd1);
        check("addi_regwr", 32'(id_reg_write), 32'd1);
        check("addi_pc",    id_pc, 32'h100);

        // SW x2,8(x3)
        if_instr = 32'h0021A423; if_pc = 32'h104;
        #1;
        check("sw_rs1_comb", 32'(rs1_addr), 32'd3);
        check("sw_rs2_comb", 32'(rs2_addr), 32'd2);
        step();
        check("sw_imm",    id_imm, 32'd8);
        check("sw_memwr",  32'(id_mem_write), 32'd1);
        check("sw_f3",     32'(id_mem_funct3), 32'd2);
        check("sw_rd",     32'(id_rd), 32'd0);
        check("sw_regwr",  32'(id_reg_write), 32'd0);
        check("sw_pc",     id_pc, 32'h104);

        // BEQ x0,x0,-4 then stall with LUI offered
        if_instr = 32'hFE000EE3; if_pc = 32'h108;
        step();
        check("beq_imm",    id_imm, 32'hFFFFFFFC);
        check("beq_branch", 32'(id_branch), 32'd1);
        check("beq_rd",     32'(id_rd), 32'd0);
        ex_ready = 1'b0;
        if_instr = 32'h123453B7; if_pc = 32'h10C;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ready", 32'(if_ready), 32'd0);
            check("stall_rs1",   32'(rs1_addr), 32'd0);
            check("stall_rs2",   32'(rs2_addr), 32'd0);
            step();
            check("stall_valid", 32'(id_valid), 32'd1);
            check("stall_imm",   id_imm, 32'hFFFFFFFC);
            check("stall_pc",    id_pc, 32'h108);
            check("stall_branch",32'(id_branch), 32'd1);
        end
        ex_ready = 1'b1;
        #1;
        check("rel_ready", 32'(if_ready), 32'd1);
        check("rel_rs1",   32'(rs1_addr), 32'd8);
        check("rel_rs2",   32'(rs2_addr), 32'd3);
        step();
        check("lui_valid", 32'(id_valid), 32'd1);
        check("lui_imm",   id_imm, 32'h12345000);
        check("lui_alu",   32'(id_alu_op), 32'd10);
        check("lui_rd",    32'(id_rd), 32'd7);
        check("lui_pc",    id_pc, 32'h10C);
        check("lui_branch",32'(id_branch), 32'd0);

        // Illegal all-zero word back-to-back
        if_instr = 32'h00000000; if_pc = 32'h110;
        step();
        check("ill_valid",   32'(id_valid), 32'd1);
        check("ill_illegal", 32'(id_illegal), 32'd1);
        check("ill_regwr",   32'(id_reg_write), 32'd0);
        check("ill_rd",      32'(id_rd), 32'd0);
        check("ill_pc",      id_pc, 32'h110);

        // Flush with ADDI x6,x1,10 offered
        if_instr = 32'h00A08313; if_pc = 32'h114; flush = 1'b1;
        #1;
        check("fl_rs1_held", 32'(rs1_addr), 32'd0);
        step();
        check("fl_valid", 32'(id_valid), 32'd0);
        check("fl_pc_held", id_pc, 32'h110);
        flush = 1'b0;
        step();
        check("refl_valid", 32'(id_valid), 32'd1);
        check("refl_rd",    32'(id_rd), 32'd6);
        check("refl_imm",   id_imm, 32'd10);
        check("refl_pc",    id_pc, 32'h114);
        check("refl_ill",   32'(id_illegal), 32'd0);

        // SUB x3,x1,x2
        if_instr = 32'h402081B3; if_pc = 32'h118;
        step();
        check("sub_alu",    32'(id_alu_op), 32'd1);
        check("sub_srcimm", 32'(id_alu_src_imm), 32'd0);
        check("sub_rd",     32'(id_rd), 32'd3);

        // SRAI x4,x4,2
        if_instr = 32'h40225213; if_pc = 32'h11C;
        step();
        check("srai_alu", 32'(id_alu_op), 32'd7);
        check("srai_rd",  32'(id_rd), 32'd4);

        // JAL x1,8
        if_instr = 32'h008000EF; if_pc = 32'h120;
        step();
        check("jal_jump",  32'(id_jump), 32'd1);
        check("jal_srcpc", 32'(id_alu_src_pc), 32'd1);
        check("jal_imm",   id_imm, 32'd8);
        check("jal_rd",    32'(id_rd), 32'd1);

        // Consume with nothing offered
        if_valid = 1'b0;
        step();
        check("drain_valid", 32'(id_valid), 32'd0);

        // Reset mid-operation drops the bundle
        if_valid = 1'b1; if_instr = 32'hFFD08293; if_pc = 32'h200;
        step();
        check("pre_rst_valid", 32'(id_valid), 32'd1);
        resetn = 1'b0; if_valid = 1'b0;
        step();
        check("mid_rst_valid", 32'(id_valid), 32'd0);
        check("mid_rst_imm",   id_imm, 32'd0);
        check("mid_rst_rs1",   32'(rs1_addr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
